// File: rtl/apb_regbank_if.sv
// APB3 slave front-end for the SPI register bank: base/index decode, one-cycle
// register strobes, PREADY stretching until acknowledge, and PSLVERR on bad index or timeout.
module apb_regbank_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 16,
  parameter int IDX_W   = 4,
  parameter int N_REG   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                      i_PCLK,
  input  logic                      i_PRESET,
  input  logic                      i_PSEL,
  input  logic                      i_PENABLE,
  input  logic                      i_PWRITE,
  input  logic [ADDR_W-1:0]         i_PADDR,
  input  logic [DATA_W-1:0]         i_PWDATA,
  input  logic [ADDR_W-IDX_W-3:0]   i_BASE_ADDR,
  output logic                      o_PREADY,
  output logic                      o_PSLVERR,
  output logic [DATA_W-1:0]         o_PRDATA,
  output logic [N_REG-1:0]          o_WR,
  output logic [N_REG-1:0]          o_RD,
  output logic [DATA_W-1:0]         o_WDATA,
  input  logic [DATA_W-1:0]         i_RDATA,
  input  logic                      i_ACK,
  output logic [7:0]                o_ERR_CNT
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx_q, idx_nxt, addr_idx;
  logic              write_q, write_nxt;
  logic [CNT_W-1:0]  tmo_q, tmo_nxt;
  logic [N_REG-1:0]  wr_nxt, rd_nxt;
  logic [DATA_W-1:0] wdata_nxt, prdata_nxt;
  logic              pready_nxt, pslverr_nxt, err_inc;
  logic              setup_hit, addr_in_range, idx_in_range;
  logic              unused_addr_bits;

  // Byte-lane bits of PADDR carry no meaning for a word-indexed register bank
  assign unused_addr_bits = ^i_PADDR[1:0];

  assign addr_idx      = i_PADDR[IDX_W+1:2];
  assign setup_hit     = i_PSEL && !i_PENABLE &&
                         (i_PADDR[ADDR_W-1:IDX_W+2] == i_BASE_ADDR);
  assign addr_in_range = ({1'b0, addr_idx} < (IDX_W+1)'(N_REG));
  assign idx_in_range  = ({1'b0, idx_q} < (IDX_W+1)'(N_REG));

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx_q;
    write_nxt   = write_q;
    tmo_nxt     = tmo_q;
    wr_nxt      = '0;
    rd_nxt      = '0;
    wdata_nxt   = o_WDATA;
    pready_nxt  = 1'b0;
    pslverr_nxt = 1'b0;
    prdata_nxt  = '0;
    err_inc     = 1'b0;

    case (state)
      IDLE: begin
        if (setup_hit) begin
          state_nxt = ACCESS;
          idx_nxt   = addr_idx;
          write_nxt = i_PWRITE;
          tmo_nxt   = '0;
          wdata_nxt = i_PWRITE ? i_PWDATA : '0;
          if (addr_in_range) begin
            if (i_PWRITE) wr_nxt = N_REG'(1) << addr_idx;
            else          rd_nxt = N_REG'(1) << addr_idx;
          end
        end
      end

      ACCESS: begin
        if (!i_PSEL) begin
          state_nxt = IDLE;
        end else if (!idx_in_range) begin
          state_nxt   = DONE;
          pready_nxt  = 1'b1;
          pslverr_nxt = 1'b1;
          err_inc     = 1'b1;
        end else if (i_ACK) begin
          state_nxt  = DONE;
          pready_nxt = 1'b1;
          prdata_nxt = write_q ? '0 : i_RDATA;
        end else begin
          state_nxt = WAIT;
          tmo_nxt   = CNT_W'(1);
        end
      end

      // tmo_q holds the ordinal of the current WAIT cycle; acknowledge beats timeout
      WAIT: begin
        if (!i_PSEL) begin
          state_nxt = IDLE;
        end else if (i_ACK) begin
          state_nxt  = DONE;
          pready_nxt = 1'b1;
          prdata_nxt = write_q ? '0 : i_RDATA;
        end else if (TIMEOUT != 0) begin
          if (tmo_q == CNT_W'(TIMEOUT)) begin
            state_nxt   = DONE;
            pready_nxt  = 1'b1;
            pslverr_nxt = 1'b1;
            err_inc     = 1'b1;
          end else begin
            tmo_nxt = tmo_q + CNT_W'(1);
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) begin
      state     <= IDLE;
      idx_q     <= '0;
      write_q   <= 1'b0;
      tmo_q     <= '0;
      o_WR      <= '0;
      o_RD      <= '0;
      o_WDATA   <= '0;
      o_PREADY  <= 1'b0;
      o_PSLVERR <= 1'b0;
      o_PRDATA  <= '0;
      o_ERR_CNT <= '0;
    end else begin
      state     <= state_nxt;
      idx_q     <= idx_nxt;
      write_q   <= write_nxt;
      tmo_q     <= tmo_nxt;
      o_WR      <= wr_nxt;
      o_RD      <= rd_nxt;
      o_WDATA   <= wdata_nxt;
      o_PREADY  <= pready_nxt;
      o_PSLVERR <= pslverr_nxt;
      o_PRDATA  <= prdata_nxt;
      if (err_inc && (o_ERR_CNT != 8'hFF)) o_ERR_CNT <= o_ERR_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_apb_regbank_if.sv
// Directed bench for apb_regbank_if with default parameters (8-bit data, 4 registers, TIMEOUT 15).
module tb_apb_regbank_if;

  logic        i_PCLK;
  logic        i_PRESET;
  logic        i_PSEL;
  logic        i_PENABLE;
  logic        i_PWRITE;
  logic [15:0] i_PADDR;
  logic [7:0]  i_PWDATA;
  logic [9:0]  i_BASE_ADDR;
  logic        o_PREADY;
  logic        o_PSLVERR;
  logic [7:0]  o_PRDATA;
  logic [3:0]  o_WR;
  logic [3:0]  o_RD;
  logic [7:0]  o_WDATA;
  logic [7:0]  i_RDATA;
  logic        i_ACK;
  logic [7:0]  o_ERR_CNT;

  int assertCount = 0;
  int failCount   = 0;

  apb_regbank_if #(
    .DATA_W(8), .ADDR_W(16), .IDX_W(4), .N_REG(4), .TIMEOUT(15)
  ) dut (
    .i_PCLK(i_PCLK), .i_PRESET(i_PRESET), .i_PSEL(i_PSEL), .i_PENABLE(i_PENABLE),
    .i_PWRITE(i_PWRITE), .i_PADDR(i_PADDR), .i_PWDATA(i_PWDATA),
    .i_BASE_ADDR(i_BASE_ADDR), .o_PREADY(o_PREADY), .o_PSLVERR(o_PSLVERR),
    .o_PRDATA(o_PRDATA), .o_WR(o_WR), .o_RD(o_RD), .o_WDATA(o_WDATA),
    .i_RDATA(i_RDATA), .i_ACK(i_ACK), .o_ERR_CNT(o_ERR_CNT)
  );

  initial begin
    i_PCLK = 1'b0;
    forever #5 i_PCLK = ~i_PCLK;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sel, input logic en, input logic wr,
                               input logic [15:0] addr, input logic [7:0] wdata,
                               input logic ack, input logic [7:0] rdata);
    i_PSEL    = sel;
    i_PENABLE = en;
    i_PWRITE  = wr;
    i_PADDR   = addr;
    i_PWDATA  = wdata;
    i_ACK     = ack;
    i_RDATA   = rdata;
  endtask

  task automatic tick();
    @(posedge i_PCLK);
    #1;
  endtask

  // Setup phase in the current cycle, returns 1 ns into C1 with the access phase driven
  task automatic startXfer(input logic wr, input logic [15:0] addr, input logic [7:0] wdata);
    tick();
    applyStimulus(1'b1, 1'b0, wr, addr, wdata, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b1, 1'b1, wr, addr, wdata, 1'b0, 8'h00);
  endtask

  task automatic idleBus();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    idleBus();
    i_BASE_ADDR = 10'h012;
    i_PRESET    = 1'b1;
    #12;
    checkOutput("rst_pready",  32'(o_PREADY),  32'h0);
    checkOutput("rst_pslverr", 32'(o_PSLVERR), 32'h0);
    checkOutput("rst_prdata",  32'(o_PRDATA),  32'h0);
    checkOutput("rst_wr",      32'(o_WR),      32'h0);
    checkOutput("rst_rd",      32'(o_RD),      32'h0);
    checkOutput("rst_wdata",   32'(o_WDATA),   32'h0);
    checkOutput("rst_errcnt",  32'(o_ERR_CNT), 32'h0);
    tick();
    i_PRESET = 1'b0;

    $display("[TB] write with immediate acknowledge");
    startXfer(1'b1, 16'h0484, 8'hA5);
    i_ACK = 1'b1;
    @(negedge i_PCLK);
    checkOutput("w1_wr",     32'(o_WR),     32'h2);
    checkOutput("w1_rd",     32'(o_RD),     32'h0);
    checkOutput("w1_wdata",  32'(o_WDATA),  32'hA5);
    checkOutput("w1_pready_c1", 32'(o_PREADY), 32'h0);
    tick();
    i_ACK = 1'b0;
    @(negedge i_PCLK);
    checkOutput("w1_pready", 32'(o_PREADY),  32'h1);
    checkOutput("w1_pslverr", 32'(o_PSLVERR), 32'h0);
    checkOutput("w1_wr_c2",  32'(o_WR),      32'h0);
    tick();
    idleBus();
    @(negedge i_PCLK);
    checkOutput("w1_pready_c3", 32'(o_PREADY), 32'h0);

    $display("[TB] read with acknowledge in third WAIT cycle");
    startXfer(1'b0, 16'h0480, 8'h00);
    @(negedge i_PCLK);
    checkOutput("r1_rd",    32'(o_RD),    32'h1);
    checkOutput("r1_wr",    32'(o_WR),    32'h0);
    checkOutput("r1_wdata", 32'(o_WDATA), 32'h0);
    tick();
    tick();
    tick();
    i_ACK   = 1'b1;
    i_RDATA = 8'h3C;
    @(negedge i_PCLK);
    checkOutput("r1_pready_c4", 32'(o_PREADY), 32'h0);
    tick();
    i_ACK   = 1'b0;
    i_RDATA = 8'h77;
    @(negedge i_PCLK);
    checkOutput("r1_pready",  32'(o_PREADY),  32'h1);
    checkOutput("r1_prdata",  32'(o_PRDATA),  32'h3C);
    checkOutput("r1_pslverr", 32'(o_PSLVERR), 32'h0);
    tick();
    idleBus();
    @(negedge i_PCLK);
    checkOutput("r1_prdata_c6", 32'(o_PRDATA), 32'h0);
    checkOutput("r1_pready_c6", 32'(o_PREADY), 32'h0);

    $display("[TB] out-of-range index");
    startXfer(1'b1, 16'h0494, 8'h5A);
    @(negedge i_PCLK);
    checkOutput("oor_wr", 32'(o_WR), 32'h0);
    checkOutput("oor_rd", 32'(o_RD), 32'h0);
    tick();
    @(negedge i_PCLK);
    checkOutput("oor_pready",  32'(o_PREADY),  32'h1);
    checkOutput("oor_pslverr", 32'(o_PSLVERR), 32'h1);
    checkOutput("oor_errcnt",  32'(o_ERR_CNT), 32'h1);
    tick();
    idleBus();

    $display("[TB] timeout with no acknowledge");
    startXfer(1'b0, 16'h0488, 8'h00);
    repeat (15) tick();
    @(negedge i_PCLK);
    checkOutput("to_pready_c16", 32'(o_PREADY), 32'h0);
    tick();
    @(negedge i_PCLK);
    checkOutput("to_pready",  32'(o_PREADY),  32'h1);
    checkOutput("to_pslverr", 32'(o_PSLVERR), 32'h1);
    checkOutput("to_prdata",  32'(o_PRDATA),  32'h0);
    checkOutput("to_errcnt",  32'(o_ERR_CNT), 32'h2);
    tick();
    idleBus();

    $display("[TB] acknowledge in fifteenth WAIT cycle");
    startXfer(1'b0, 16'h0488, 8'h00);
    repeat (15) tick();
    i_ACK   = 1'b1;
    i_RDATA = 8'h99;
    tick();
    i_ACK = 1'b0;
    @(negedge i_PCLK);
    checkOutput("ack15_pready",  32'(o_PREADY),  32'h1);
    checkOutput("ack15_pslverr", 32'(o_PSLVERR), 32'h0);
    checkOutput("ack15_prdata",  32'(o_PRDATA),  32'h99);
    checkOutput("ack15_errcnt",  32'(o_ERR_CNT), 32'h2);
    tick();
    idleBus();

    $display("[TB] base mismatch");
    startXfer(1'b1, 16'h0884, 8'h11);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_PCLK);
      checkOutput("mm_pready",  32'(o_PREADY),    32'h0);
      checkOutput("mm_strobes", 32'({o_WR, o_RD}), 32'h0);
      tick();
    end
    idleBus();

    $display("[TB] abort in WAIT");
    startXfer(1'b0, 16'h0480, 8'h00);
    @(negedge i_PCLK);
    checkOutput("ab_rd", 32'(o_RD), 32'h1);
    tick();
    idleBus();
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge i_PCLK);
      checkOutput("ab_pready", 32'(o_PREADY), 32'h0);
    end
    checkOutput("ab_errcnt", 32'(o_ERR_CNT), 32'h2);
    checkOutput("ab_rd_end", 32'(o_RD),      32'h0);

    $display("[TB] reset during WAIT");
    startXfer(1'b1, 16'h048C, 8'hC3);
    @(negedge i_PCLK);
    checkOutput("rw_wr",    32'(o_WR),    32'h8);
    checkOutput("rw_wdata", 32'(o_WDATA), 32'hC3);
    tick();
    @(negedge i_PCLK);
    i_PRESET = 1'b1;
    #1;
    checkOutput("rw_rst_wdata",   32'(o_WDATA),   32'h0);
    checkOutput("rw_rst_errcnt",  32'(o_ERR_CNT), 32'h0);
    checkOutput("rw_rst_strobes", 32'({o_WR, o_RD}), 32'h0);
    checkOutput("rw_rst_resp",    32'({o_PREADY, o_PSLVERR, o_PRDATA}), 32'h0);
    idleBus();
    tick();
    i_PRESET = 1'b0;
    startXfer(1'b1, 16'h0488, 8'h3E);
    i_ACK = 1'b1;
    @(negedge i_PCLK);
    checkOutput("post_wr",    32'(o_WR),    32'h4);
    checkOutput("post_wdata", 32'(o_WDATA), 32'h3E);
    tick();
    i_ACK = 1'b0;
    @(negedge i_PCLK);
    checkOutput("post_pready",  32'(o_PREADY),  32'h1);
    checkOutput("post_pslverr", 32'(o_PSLVERR), 32'h0);
    tick();
    idleBus();

    $display("[TB] error counter saturation, back-to-back");
    for (int i = 0; i < 254; i++) begin
      startXfer(1'b0, 16'h0494, 8'h00);
      tick();
    end
    @(negedge i_PCLK);
    checkOutput("sat_254", 32'(o_ERR_CNT), 32'hFE);
    startXfer(1'b0, 16'h0494, 8'h00);
    tick();
    @(negedge i_PCLK);
    checkOutput("sat_255",         32'(o_ERR_CNT), 32'hFF);
    checkOutput("sat_255_pslverr", 32'(o_PSLVERR), 32'h1);
    startXfer(1'b0, 16'h0494, 8'h00);
    tick();
    @(negedge i_PCLK);
    checkOutput("sat_256",        32'(o_ERR_CNT), 32'hFF);
    checkOutput("sat_256_pready", 32'(o_PREADY),  32'h1);
    tick();
    idleBus();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
